// File: rtl/block_mod20.sv
// Modulo-MODULUS up/down counter advanced by a programmable prescaler tick.
// Optional ping-pong mode 11 is enabled by BLOCK_MOD20_PINGPONG_EN.
module block_mod20 #(
  parameter int DIV     = 50_000_000,
  parameter int MODULUS = 20
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       S0,
  input  logic       S1,
  output logic [4:0] Output
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [4:0] MAX = 5'(MODULUS - 1);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_11   = 2'b11;

  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    mode;
  logic [4:0]    inc;
  logic [4:0]    dec;
  logic [4:0]    nxt;
  logic          oor;

  // With DIV=1 presc is pinned at 0 == PMAX, so tick stays high.
  assign tick = (presc == PMAX);
  assign mode = {S1, S0};
  assign inc  = Output + 5'd1;
  assign dec  = Output - 5'd1;
  assign oor  = (Output > MAX);

  always_ff @(posedge clk_50M) begin
    if (reset || tick) presc <= '0;
    else               presc <= presc + 1'b1;
  end

`ifdef BLOCK_MOD20_PINGPONG_EN
  logic dir_up;
  logic dir_nxt;

  always_comb begin
    nxt     = Output;
    dir_nxt = dir_up;
    if (oor) begin
      nxt = '0;
    end else begin
      unique case (mode)
        M_HOLD: nxt = Output;
        M_UP:   nxt = (Output == MAX) ? 5'd0 : inc;
        M_DN:   nxt = (Output == 5'd0) ? MAX : dec;
        M_11: begin
          // Flip in the same tick that lands on an endpoint.
          if (dir_up) begin
            if (Output == MAX) begin
              nxt     = dec;
              dir_nxt = 1'b0;
            end else begin
              nxt = inc;
              if (inc == MAX) dir_nxt = 1'b0;
            end
          end else begin
            if (Output == 5'd0) begin
              nxt     = inc;
              dir_nxt = 1'b1;
            end else begin
              nxt = dec;
              if (dec == 5'd0) dir_nxt = 1'b1;
            end
          end
        end
        default: nxt = Output;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset)     dir_up <= 1'b1;
    else if (tick) dir_up <= dir_nxt;
  end
`else
  always_comb begin
    nxt = Output;
    if (oor) begin
      nxt = '0;
    end else begin
      unique case (mode)
        M_HOLD:  nxt = Output;
        M_UP:    nxt = (Output == MAX) ? 5'd0 : inc;
        M_DN:    nxt = (Output == 5'd0) ? MAX : dec;
        M_11:    nxt = '0;
        default: nxt = Output;
      endcase
    end
  end
`endif

  always_ff @(posedge clk_50M) begin
    if (reset)     Output <= '0;
    else if (tick) Output <= nxt;
  end

endmodule

// File: tb/tb_block_mod20.sv
// Randomized/directed bench for block_mod20 with DIV=1 and DIV=4 instances.
// Expected values come from an arithmetic reference model.
module tb_block_mod20;

  localparam int M = 20;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       S0;
  logic       S1;
  logic [4:0] q1;
  logic [4:0] q4;

  int checks   = 0;
  int failures = 0;

  int divs [2] = '{1, 4};
  int cnt  [2];
  int since[2];
  bit dirup[2];

  always #10 clk_50M = ~clk_50M;

  block_mod20 #(.DIV(1), .MODULUS(M)) u1 (
    .clk_50M(clk_50M), .reset(reset), .S0(S0), .S1(S1), .Output(q1)
  );

  block_mod20 #(.DIV(4), .MODULUS(M)) u4 (
    .clk_50M(clk_50M), .reset(reset), .S0(S0), .S1(S1), .Output(q4)
  );

  task automatic chk(input string tag, input logic [4:0] got, input int exp);
    checks++;
    assert (got === 5'(exp))
    else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input int j, input logic [1:0] m, input logic r);
    int p;
    bit tk;
    if (r) begin
      cnt[j]   = 0;
      since[j] = 0;
      dirup[j] = 1'b1;
      return;
    end
    tk = ((since[j] % divs[j]) == divs[j] - 1);
    since[j]++;
    if (!tk) return;
    if (cnt[j] > M - 1) begin
      cnt[j] = 0;
      return;
    end
    case (m)
      2'd1: cnt[j] = (cnt[j] + 1) % M;
      2'd2: cnt[j] = (cnt[j] + M - 1) % M;
      2'd3: begin
`ifdef BLOCK_MOD20_PINGPONG_EN
        // Position on a triangle wave of period 2(M-1).
        p = dirup[j] ? cnt[j] : (2*M - 2 - cnt[j]) % (2*M - 2);
        p = (p + 1) % (2*M - 2);
        cnt[j]   = (p < M) ? p : 2*M - 2 - p;
        dirup[j] = (p < M - 1);
`else
        p = 0;
        cnt[j] = p;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic [1:0] m, input logic r);
    S1    = m[1];
    S0    = m[0];
    reset = r;
    @(posedge clk_50M);
    model(0, m, r);
    model(1, m, r);
    #1;
    chk("div1", q1, cnt[0]);
    chk("div4", q4, cnt[1]);
  endtask

  initial begin
    reset = 1'b1;
    S0    = 1'b0;
    S1    = 1'b0;

    step(2'b01, 1'b1);
    step(2'b01, 1'b1);
    chk("reset_div1", q1, 0);
    chk("reset_div4", q4, 0);

    step(2'b01, 1'b0);
    chk("first_up_div1", q1, 1);
    chk("hold_div4", q4, 0);
    for (int i = 0; i < 24; i++) step(2'b01, 1'b0);

    step(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) step(2'b01, 1'b0);
    chk("up5", q1, 5);
    for (int i = 0; i < 7; i++) step(2'b10, 1'b0);
    chk("down_wrap", q1, 18);
    for (int i = 0; i < 10; i++) step(2'b00, 1'b0);
    chk("hold18", q1, 18);

    step(2'b00, 1'b1);
    for (int i = 0; i < 12; i++) step(2'b01, 1'b0);
    for (int i = 0; i < 45; i++) step(2'b11, 1'b0);

    step(2'b00, 1'b1);
    for (int i = 0; i < 45; i++) step(2'b11, 1'b0);

    step(2'b00, 1'b1);
    for (int i = 0; i < 7; i++) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    chk("mid_reset", q1, 0);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0);
    chk("resume", q1, 3);

    for (int i = 0; i < 600; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
